alu_exec_seq: RTL and testbench

//  Sequences one register-to-register ALU instruction (ADD..CMP) through the execute steps of the 7-step processor.

---
 rtl/alu_exec_pkg.sv | 31 +++
 rtl/alu_flags_reg.sv | 22 ++
 rtl/alu_exec_seq.sv | 136 +++++++++++++
 tb/tb_alu_exec_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the register-to-register ALU execute sequencer:
// opcode constants, FSM state encoding and flag bit positions.
package alu_exec_pkg;

  localparam logic [2:0] OP_ADD = 3'o0;
  localparam logic [2:0] OP_SHR = 3'o1;
  localparam logic [2:0] OP_SHL = 3'o2;
  localparam logic [2:0] OP_NOT = 3'o3;
  localparam logic [2:0] OP_AND = 3'o4;
  localparam logic [2:0] OP_OR  = 3'o5;
  localparam logic [2:0] OP_XOR = 3'o6;
  localparam logic [2:0] OP_CMP = 3'o7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LD_TMP = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  localparam int FLG_C = 3;
  localparam int FLG_A = 2;
  localparam int FLG_E = 1;
  localparam int FLG_Z = 0;

  // Bit 7 of an instruction word marks it as a register-to-register ALU op.
  function automatic logic is_alu_instr(input logic [7:0] instr);
    return instr[7];
  endfunction

endpackage

// File: rtl/alu_flags_reg.sv
// Four-bit {C,A,E,Z} flag register with load enable and synchronous
// active-low reset.
module alu_flags_reg
  import alu_exec_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Flags load only on request and otherwise hold their value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= 4'b0000;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Execute sequencer for one ALU instruction: IDLE -> LD_TMP -> EXEC -> WB.
// Optional macro CARRY_CHAIN_EN feeds the registered carry flag into alu_c_in.
module alu_exec_seq
  import alu_exec_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2,
  parameter int OP_W       = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            instr,
  output logic [REG_ADDR_W-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0]     reg_rd_data,
  output logic                  reg_wr_en,
  output logic [REG_ADDR_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0]     reg_wr_data,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [OP_W-1:0]       alu_op,
  output logic                  alu_c_in,
  input  logic [DATA_W-1:0]     alu_c,
  input  logic                  alu_c_out,
  input  logic                  alu_a_larger,
  input  logic                  alu_equal,
  input  logic                  alu_zero,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            flags
);

  state_t              state_r;
  state_t              state_s;
  logic [6:0]          instr_r;
  logic [DATA_W-1:0]   tmp_r;
  logic [DATA_W-1:0]   acc_r;
  logic                busy_r;
  logic                done_r;
  logic                wr_en_r;
  logic                flags_load_s;
  logic                accept_s;
  logic [OP_W-1:0]     op_s;
  logic [REG_ADDR_W-1:0] ra_s;
  logic [REG_ADDR_W-1:0] rb_s;

  assign op_s     = instr_r[6:4];
  assign ra_s     = instr_r[3:2];
  assign rb_s     = instr_r[1:0];
  assign accept_s = start && is_alu_instr(instr);

  // Next-state and per-state datapath steering; ALU sees ADD/0 outside EXEC.
  always_comb begin
    state_s      = state_r;
    reg_rd_addr  = '0;
    alu_a        = '0;
    alu_op       = OP_ADD;
    flags_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_LD_TMP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LD_TMP: begin
        reg_rd_addr = rb_s;
        state_s     = ST_EXEC;
      end
      ST_EXEC: begin
        reg_rd_addr  = ra_s;
        alu_a        = reg_rd_data;
        alu_op       = op_s;
        flags_load_s = 1'b1;
        state_s      = ST_WB;
      end
      ST_WB: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, operand/result registers and registered status strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      instr_r <= 7'd0;
      tmp_r   <= '0;
      acc_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wr_en_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_WB);
      wr_en_r <= (state_s == ST_WB) && (op_s != OP_CMP);
      if ((state_r == ST_IDLE) && accept_s) begin
        instr_r <= instr[6:0];
      end
      if (state_r == ST_LD_TMP) begin
        tmp_r <= reg_rd_data;
      end
      // CMP only produces flags, so ACC keeps the previous result.
      if ((state_r == ST_EXEC) && (op_s != OP_CMP)) begin
        acc_r <= alu_c;
      end
    end
  end

  alu_flags_reg u_flags (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (flags_load_s),
    .d       ({alu_c_out, alu_a_larger, alu_equal, alu_zero}),
    .q       (flags)
  );

  assign alu_b       = tmp_r;
  assign reg_wr_addr = rb_s;
  assign reg_wr_data = acc_r;
  assign reg_wr_en   = wr_en_r;
  assign done        = done_r;
  assign busy        = busy_r;

`ifdef CARRY_CHAIN_EN
  assign alu_c_in = flags[FLG_C];
`else
  assign alu_c_in = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed self-checking bench for alu_exec_seq with a behavioural ALU and
// a four-entry register file.
module tb_alu_exec_seq;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] instr;
  logic [1:0] reg_rd_addr;
  logic [7:0] reg_rd_data;
  logic       reg_wr_en;
  logic [1:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic       alu_c_in;
  logic [7:0] alu_c;
  logic       alu_c_out;
  logic       alu_a_larger;
  logic       alu_equal;
  logic       alu_zero;
  logic       busy;
  logic       done;
  logic [3:0] flags;

  logic [7:0] regs [4];
  logic       pre_en;
  logic [1:0] pre_addr;
  logic [7:0] pre_data;
  int         wr_count;
  int         done_count;
  int         checks;
  int         errors;

`ifdef CARRY_CHAIN_EN
  localparam logic [7:0] RSH_EXP  = 8'h81;
  localparam logic       CIN_EXP  = 1'b1;
`else
  localparam logic [7:0] RSH_EXP  = 8'h01;
  localparam logic       CIN_EXP  = 1'b0;
`endif

  alu_exec_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .instr        (instr),
    .reg_rd_addr  (reg_rd_addr),
    .reg_rd_data  (reg_rd_data),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_c_in     (alu_c_in),
    .alu_c        (alu_c),
    .alu_c_out    (alu_c_out),
    .alu_a_larger (alu_a_larger),
    .alu_equal    (alu_equal),
    .alu_zero     (alu_zero),
    .busy         (busy),
    .done         (done),
    .flags        (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: comparison flags are only produced by CMP.
  always_comb begin
    alu_c        = 8'h00;
    alu_c_out    = 1'b0;
    alu_a_larger = 1'b0;
    alu_equal    = 1'b0;
    case (alu_op)
      3'o0: {alu_c_out, alu_c} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_c_in};
      3'o1: begin alu_c = {alu_c_in, alu_a[7:1]}; alu_c_out = alu_a[0]; end
      3'o2: begin alu_c = {alu_a[6:0], alu_c_in}; alu_c_out = alu_a[7]; end
      3'o3: alu_c = ~alu_a;
      3'o4: alu_c = alu_a & alu_b;
      3'o5: alu_c = alu_a | alu_b;
      3'o6: alu_c = alu_a ^ alu_b;
      default: begin
        alu_c        = alu_a ^ alu_b;
        alu_a_larger = (alu_a > alu_b);
        alu_equal    = (alu_a == alu_b);
      end
    endcase
    alu_zero = (alu_c == 8'h00);
  end

  assign reg_rd_data = regs[reg_rd_addr];

  // Register file writes (preload or DUT write-back) and event counters.
  always @(posedge clk) begin
    if (pre_en) regs[pre_addr] <= pre_data;
    else if (reg_wr_en) regs[reg_wr_addr] <= reg_wr_data;
    if (reg_wr_en) wr_count <= wr_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic set_reg(input logic [1:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Presents start for one edge; returns at the negedge of cycle 1.
  task automatic issue(input logic [7:0] ins);
    start = 1'b1; instr = ins;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b exp 0", reg_wr_en); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags); end
    checks++; if (reg_wr_data !== 8'h00) begin errors++; $display("FAIL reset_acc got %h exp 00", reg_wr_data); end
    checks++; if (alu_b !== 8'h00) begin errors++; $display("FAIL reset_tmp got %h exp 00", alu_b); end
    checks++; if (alu_a !== 8'h00 || alu_op !== 3'o0) begin errors++; $display("FAIL reset_alu_in got a=%h op=%0d exp a=00 op=0", alu_a, alu_op); end
    reset_n = 1'b1;
  endtask

  task automatic test_non_alu;
    int w0, d0;
    w0 = wr_count; d0 = done_count;
    issue(8'h12);
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nonalu_busy cyc%0d got %0b exp 0", i + 1, busy); end
      @(negedge clk);
    end
    checks++; if (wr_count !== w0 || done_count !== d0) begin errors++; $display("FAIL nonalu_events got wr=%0d done=%0d exp wr=%0d done=%0d", wr_count, done_count, w0, d0); end
  endtask

  task automatic test_add;
    int d0;
    set_reg(2'd0, 8'h80); set_reg(2'd1, 8'h80);
    d0 = done_count;
    issue(8'h81);
    checks++; if (busy !== 1'b1 || done !== 1'b0 || reg_rd_addr !== 2'd1) begin errors++; $display("FAIL add_cyc1 got busy=%0b done=%0b rd=%0d exp 1 0 1", busy, done, reg_rd_addr); end
    @(negedge clk);
    checks++; if (alu_a !== 8'h80 || alu_b !== 8'h80 || alu_op !== 3'o0 || done !== 1'b0) begin errors++; $display("FAIL add_exec got a=%h b=%h op=%0d done=%0b exp 80 80 0 0", alu_a, alu_b, alu_op, done); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || reg_wr_en !== 1'b1) begin errors++; $display("FAIL add_cyc3 got done=%0b wr=%0b exp 1 1", done, reg_wr_en); end
    checks++; if (reg_wr_addr !== 2'd1 || reg_wr_data !== 8'h00) begin errors++; $display("FAIL add_wb got addr=%0d data=%h exp 1 00", reg_wr_addr, reg_wr_data); end
    @(negedge clk);
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL add_flags got %b exp 1001", flags); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || done_count !== d0 + 1) begin errors++; $display("FAIL add_retire got busy=%0b done=%0b dones=%0d exp 0 0 %0d", busy, done, done_count, d0 + 1); end
    checks++; if (regs[1] !== 8'h00) begin errors++; $display("FAIL add_reg got %h exp 00", regs[1]); end
  endtask

  task automatic test_rsh_carry;
    set_reg(2'd2, 8'h02); set_reg(2'd3, 8'h55);
    issue(8'h9B);
    @(negedge clk);
    checks++; if (alu_c_in !== CIN_EXP || alu_op !== 3'o1) begin errors++; $display("FAIL rsh_cin got cin=%0b op=%0d exp %0b 1", alu_c_in, alu_op, CIN_EXP); end
    @(negedge clk);
    checks++; if (reg_wr_en !== 1'b1 || reg_wr_data !== RSH_EXP || reg_wr_addr !== 2'd3) begin errors++; $display("FAIL rsh_wb got wr=%0b data=%h addr=%0d exp 1 %h 3", reg_wr_en, reg_wr_data, reg_wr_addr, RSH_EXP); end
    @(negedge clk);
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rsh_flags got %b exp 0000", flags); end
  endtask

  task automatic test_cmp;
    int w0, d0;
    set_reg(2'd0, 8'h05); set_reg(2'd1, 8'h03);
    w0 = wr_count; d0 = done_count;
    issue(8'hF1);
    @(negedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b1 || reg_wr_en !== 1'b0) begin errors++; $display("FAIL cmp_wb got done=%0b wr=%0b exp 1 0", done, reg_wr_en); end
    @(negedge clk);
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL cmp_flags got %b exp 0100", flags); end
    checks++; if (wr_count !== w0 || done_count !== d0 + 1) begin errors++; $display("FAIL cmp_events got wr=%0d done=%0d exp %0d %0d", wr_count, done_count, w0, d0 + 1); end
    checks++; if (reg_wr_data !== RSH_EXP || regs[1] !== 8'h03) begin errors++; $display("FAIL cmp_acc got acc=%h r1=%h exp %h 03", reg_wr_data, regs[1], RSH_EXP); end
  endtask

  task automatic test_back_to_back;
    int d0;
    set_reg(2'd2, 8'hF0); set_reg(2'd3, 8'h20);
    d0 = done_count;
    issue(8'h8B);
    start = 1'b1; instr = 8'h8B;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || reg_wr_data !== 8'h10) begin errors++; $display("FAIL b2b_wb got done=%0b data=%h exp 1 10", done, reg_wr_data); end
    repeat (4) @(negedge clk);
    checks++; if (done_count !== d0 + 1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_single got dones=%0d busy=%0b exp %0d 0", done_count, busy, d0 + 1); end
    checks++; if (flags !== 4'b1000 || regs[3] !== 8'h10) begin errors++; $display("FAIL b2b_result got flags=%b r3=%h exp 1000 10", flags, regs[3]); end
  endtask

  task automatic test_reset_mid;
    int w0, d0;
    set_reg(2'd0, 8'h01); set_reg(2'd1, 8'h07);
    w0 = wr_count; d0 = done_count;
    issue(8'h81);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0 || flags !== 4'b0000 || reg_wr_data !== 8'h00) begin errors++; $display("FAIL rstmid_state got busy=%0b flags=%b acc=%h exp 0 0000 00", busy, flags, reg_wr_data); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wr_count !== w0 || done_count !== d0 || regs[1] !== 8'h07) begin errors++; $display("FAIL rstmid_abandon got wr=%0d done=%0d r1=%h exp %0d %0d 07", wr_count, done_count, regs[1], w0, d0); end
  endtask

  initial begin
    checks = 0; errors = 0; wr_count = 0; done_count = 0;
    start = 1'b0; instr = 8'h00; pre_en = 1'b0; pre_addr = 2'd0; pre_data = 8'h00;
    @(negedge clk);
    test_reset;
    for (int r = 0; r < 4; r++) set_reg(r[1:0], 8'h00);
    test_non_alu;
    test_add;
    test_rsh_carry;
    test_cmp;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
